// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Issue-side hazard tracker between decode and execute. Tracks destination
//   registers of long-latency producers (loads, and with RV32M_EN also
//   multiply/divide), stalls ID while a source or destination is not yet
//   forwardable, and drives the mul_ready/div_start handshakes.
//
// Build option:
//   RV32M_EN  defined   -> multiply/divide tracking enabled
//             undefined -> only loads tracked; mul/div outputs tied to 0
//
// Parameters:
//   MUL_LAT      multiplier latency, issue to result valid (1..15)
//
// Ports:
//   clk, rst_n               clock, async active-low reset
//   ID_valid                 ID instruction requests issue
//   ID_rs1/ID_rs2            source registers, ID_use_rs1/ID_use_rs2 read enables
//   ID_rd, ID_regwrite       destination register and its write enable
//   ID_memread               instruction is a load
//   ID_is_mul, ID_is_div     M-extension class
//   flush                    kill the ID instruction this cycle
//   div_ready                divider result valid (single-cycle pulse)
//   stall                    hold IF/ID, bubble into EX
//   div_start                one-cycle divider start pulse
//   mul_ready                multiplier result valid this cycle
//   div_busy, mul_busy       unit occupied
//   pending                  per-register not-yet-forwardable mask (bit 0 = 0)

module hazard_scoreboard #(
  parameter int unsigned MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ID_valid,
  input  logic [4:0]  ID_rs1,
  input  logic [4:0]  ID_rs2,
  input  logic        ID_use_rs1,
  input  logic        ID_use_rs2,
  input  logic [4:0]  ID_rd,
  input  logic        ID_regwrite,
  input  logic        ID_memread,
  input  logic        ID_is_mul,
  input  logic        ID_is_div,
  input  logic        flush,
  input  logic        div_ready,
  output logic        stall,
  output logic        div_start,
  output logic        mul_ready,
  output logic        div_busy,
  output logic        mul_busy,
  output logic [31:0] pending
);

  function automatic logic [31:0] onehot(input logic [4:0] r);
    return 32'd1 << r;
  endfunction

  logic [31:0] pend_q;
  logic [31:0] pend_d;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;
  logic [31:0] byp_mask;
  logic [31:0] eff;
  logic        issue;
  logic        lw;
  logic        ld_issue;
  logic        long_op;
  logic        raw;
  logic        waw;
  logic        struct_haz;
  logic        ld_valid_q;
  logic [4:0]  ld_rd_q;

  // Registers completing this cycle are forwarded, so they are masked out
  // of the hazard check even though their pending bit is still set.
  assign eff        = pend_q & ~byp_mask;
  assign raw        = (ID_use_rs1 & eff[ID_rs1]) | (ID_use_rs2 & eff[ID_rs2]);
  assign waw        = ID_regwrite & (ID_rd != '0) & eff[ID_rd];
  assign stall      = ID_valid & ~flush & (raw | waw | struct_haz);
  assign issue      = ID_valid & ~stall & ~flush;
  assign lw         = issue & ID_regwrite & (ID_rd != '0) & long_op;
  assign ld_issue   = lw & ID_memread;
  assign pending    = pend_q;

  always_comb begin
    set_mask = '0;
    clr_mask = byp_mask;
    if (lw)         set_mask = onehot(ID_rd);
    if (ld_valid_q) clr_mask = clr_mask | onehot(ld_rd_q);
    // A new issue overrides a completion on the same register.
    pend_d    = (pend_q & ~clr_mask) | set_mask;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q     <= '0;
      ld_valid_q <= 1'b0;
      ld_rd_q    <= '0;
    end else begin
      pend_q     <= pend_d;
      ld_valid_q <= ld_issue;
      if (ld_issue) ld_rd_q <= ID_rd;
    end
  end

`ifdef RV32M_EN
  localparam logic [3:0] MUL_INIT = 4'(MUL_LAT - 1);

  logic       mul_issue;
  logic       div_issue;
  logic       div_done;
  logic       mul_busy_q;
  logic       div_busy_q;
  logic [3:0] mul_cnt_q;
  logic [4:0] mul_rd_q;
  logic [4:0] div_rd_q;
  logic [4:0] dst_rd;

  assign long_op    = ID_memread | ID_is_mul | ID_is_div;
  assign mul_issue  = issue & ID_is_mul & ~ID_memread;
  assign div_issue  = issue & ID_is_div & ~ID_memread & ~ID_is_mul;
  assign mul_ready  = mul_busy_q & (mul_cnt_q == '0);
  assign div_done   = div_ready & div_busy_q;
  assign struct_haz = (ID_is_mul & mul_busy_q & ~mul_ready) |
                      (ID_is_div & div_busy_q & ~div_ready);
  assign byp_mask   = (mul_ready ? onehot(mul_rd_q) : '0) |
                      (div_done  ? onehot(div_rd_q) : '0);
  assign div_start  = div_issue;
  assign mul_busy   = mul_busy_q;
  assign div_busy   = div_busy_q;
  // Non-writing ops track x0 so their completion never clears a live bit.
  assign dst_rd     = ID_regwrite ? ID_rd : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_busy_q <= 1'b0;
      mul_cnt_q  <= '0;
      mul_rd_q   <= '0;
    end else if (mul_issue) begin
      mul_busy_q <= 1'b1;
      mul_cnt_q  <= MUL_INIT;
      mul_rd_q   <= dst_rd;
    end else if (mul_ready) begin
      mul_busy_q <= 1'b0;
    end else if (mul_busy_q && mul_cnt_q != '0) begin
      mul_cnt_q  <= mul_cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_busy_q <= 1'b0;
      div_rd_q   <= '0;
    end else if (div_issue) begin
      div_busy_q <= 1'b1;
      div_rd_q   <= dst_rd;
    end else if (div_done) begin
      div_busy_q <= 1'b0;
    end
  end
`else
  localparam int unsigned unused_lat = MUL_LAT;
  logic unused_in;

  assign unused_in  = ^{ID_is_mul, ID_is_div, div_ready};
  assign long_op    = ID_memread;
  assign struct_haz = 1'b0;
  assign byp_mask   = '0;
  assign div_start  = 1'b0;
  assign mul_ready  = 1'b0;
  assign mul_busy   = 1'b0;
  assign div_busy   = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

`ifdef RV32M_EN
  localparam logic M = 1'b1;
`else
  localparam logic M = 1'b0;
`endif

  localparam int K_ALU = 0;
  localparam int K_LD  = 1;
  localparam int K_MUL = 2;
  localparam int K_DIV = 3;

  logic        clk;
  logic        rst_n;
  logic        ID_valid;
  logic [4:0]  ID_rs1;
  logic [4:0]  ID_rs2;
  logic        ID_use_rs1;
  logic        ID_use_rs2;
  logic [4:0]  ID_rd;
  logic        ID_regwrite;
  logic        ID_memread;
  logic        ID_is_mul;
  logic        ID_is_div;
  logic        flush;
  logic        div_ready;
  logic        stall;
  logic        div_start;
  logic        mul_ready;
  logic        div_busy;
  logic        mul_busy;
  logic [31:0] pending;

  hazard_scoreboard #(.MUL_LAT(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ID_valid   (ID_valid),
    .ID_rs1     (ID_rs1),
    .ID_rs2     (ID_rs2),
    .ID_use_rs1 (ID_use_rs1),
    .ID_use_rs2 (ID_use_rs2),
    .ID_rd      (ID_rd),
    .ID_regwrite(ID_regwrite),
    .ID_memread (ID_memread),
    .ID_is_mul  (ID_is_mul),
    .ID_is_div  (ID_is_div),
    .flush      (flush),
    .div_ready  (div_ready),
    .stall      (stall),
    .div_start  (div_start),
    .mul_ready  (mul_ready),
    .div_busy   (div_busy),
    .mul_busy   (mul_busy),
    .pending    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic       ml;
    logic       dv;
    logic       fl;
    logic       dr;
  } in_t;

  typedef struct {
    string       name;
    logic        stall;
    logic        div_start;
    logic        mul_ready;
    logic        mul_busy;
    logic        div_busy;
    logic [31:0] pending;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_cur;
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [31:0] b(input int n);
    logic [31:0] one;
    one = 32'd1;
    return one << n;
  endfunction

  function automatic logic [31:0] mb(input int n);
    return M ? b(n) : 32'h0;
  endfunction

  function automatic in_t idle();
    in_t t;
    t = '{rst: 1'b1, valid: 1'b0, rs1: 5'd0, rs2: 5'd0, u1: 1'b0, u2: 1'b0,
          rd: 5'd0, rw: 1'b0, mr: 1'b0, ml: 1'b0, dv: 1'b0, fl: 1'b0, dr: 1'b0};
    return t;
  endfunction

  function automatic in_t ins(input int k, input int rd, input int rs1, input int rs2);
    in_t t;
    t       = idle();
    t.valid = 1'b1;
    t.rd    = 5'(rd);
    t.rs1   = 5'(rs1);
    t.rs2   = 5'(rs2);
    t.u1    = 1'b1;
    t.u2    = (k != K_LD);
    t.rw    = 1'b1;
    t.mr    = (k == K_LD);
    t.ml    = (k == K_MUL);
    t.dv    = (k == K_DIV);
    return t;
  endfunction

  task automatic step(input in_t i, input string nm, input logic st, input logic ds,
                      input logic mr, input logic mbz, input logic db, input logic [31:0] pd);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n       = i.rst;
    ID_valid    = i.valid;
    ID_rs1      = i.rs1;
    ID_rs2      = i.rs2;
    ID_use_rs1  = i.u1;
    ID_use_rs2  = i.u2;
    ID_rd       = i.rd;
    ID_regwrite = i.rw;
    ID_memread  = i.mr;
    ID_is_mul   = i.ml;
    ID_is_div   = i.dv;
    flush       = i.fl;
    div_ready   = i.dr;
    e = '{name: nm, stall: st, div_start: ds, mul_ready: mr, mul_busy: mbz,
          div_busy: db, pending: pd};
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s actual=%h expected=%h", nm, fld, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e_cur = exp_q.pop_front();
      chk(e_cur.name, "stall",     {31'b0, stall},     {31'b0, e_cur.stall});
      chk(e_cur.name, "div_start", {31'b0, div_start}, {31'b0, e_cur.div_start});
      chk(e_cur.name, "mul_ready", {31'b0, mul_ready}, {31'b0, e_cur.mul_ready});
      chk(e_cur.name, "mul_busy",  {31'b0, mul_busy},  {31'b0, e_cur.mul_busy});
      chk(e_cur.name, "div_busy",  {31'b0, div_busy},  {31'b0, e_cur.div_busy});
      chk(e_cur.name, "pending",   pending,            e_cur.pending);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    in_t t;
    rst_n = 1'b0;
    ID_valid = 1'b0; ID_rs1 = '0; ID_rs2 = '0; ID_use_rs1 = 1'b0; ID_use_rs2 = 1'b0;
    ID_rd = '0; ID_regwrite = 1'b0; ID_memread = 1'b0; ID_is_mul = 1'b0;
    ID_is_div = 1'b0; flush = 1'b0; div_ready = 1'b0;

    // reset state
    t = idle(); t.rst = 1'b0;
    step(t, "reset", 0, 0, 0, 0, 0, 32'h0);
    step(idle(), "post_reset", 0, 0, 0, 0, 0, 32'h0);

    // load x5 then dependent add: one stall cycle
    step(ins(K_LD, 5, 1, 0),  "ld_issue", 0, 0, 0, 0, 0, 32'h0);
    step(ins(K_ALU, 6, 5, 1), "ld_use0",  1, 0, 0, 0, 0, b(5));
    step(ins(K_ALU, 6, 5, 1), "ld_use1",  0, 0, 0, 0, 0, 32'h0);
    step(idle(),              "ld_idle",  0, 0, 0, 0, 0, 32'h0);

    // mul x7 then dependent sub: MUL_LAT-1 stall cycles, issue on mul_ready
    step(ins(K_MUL, 7, 3, 4), "mul_issue", 0, 0, 0, 0, 0, 32'h0);
    step(ins(K_ALU, 8, 7, 2), "mul_use0",  M, 0, 0, M, 0, mb(7));
    step(ins(K_ALU, 8, 7, 2), "mul_use1",  M, 0, 0, M, 0, mb(7));
    step(ins(K_ALU, 8, 7, 2), "mul_use2",  0, 0, M, M, 0, mb(7));
    step(idle(),              "mul_idle",  0, 0, 0, 0, 0, 32'h0);

    // WAW on mul destination, then load set wins over mul completion
    step(ins(K_MUL, 20, 1, 2), "waw_mul", 0, 0, 0, 0, 0, 32'h0);
    step(ins(K_LD, 20, 1, 0),  "waw_ld0", M, 0, 0, M, 0, mb(20));
    step(ins(K_LD, 20, 1, 0),  "waw_ld1", 1, 0, 0, M, 0, b(20));
    step(ins(K_LD, 20, 1, 0),  "waw_ld2", 0, 0, M, M, 0, mb(20));
    step(idle(),               "waw_set", 0, 0, 0, 0, 0, b(20));
    step(idle(),               "waw_clr", 0, 0, 0, 0, 0, 32'h0);

    // div x9, dependent or waits 10 cycles, released the div_ready cycle
    step(ins(K_DIV, 9, 1, 2), "div_issue", 0, M, 0, 0, 0, 32'h0);
    for (int k = 0; k < 10; k++)
      step(ins(K_ALU, 10, 9, 3), "div_wait", M, 0, 0, 0, M, mb(9));
    t = ins(K_ALU, 10, 9, 3); t.dr = 1'b1;
    step(t,      "div_done", 0, 0, 0, 0, M, mb(9));
    step(idle(), "div_idle", 0, 0, 0, 0, 0, 32'h0);

    // second div while busy: structural stall, issue in div_ready cycle
    step(ins(K_DIV, 11, 1, 2), "div2_a", 0, M, 0, 0, 0, 32'h0);
    step(ins(K_DIV, 12, 3, 4), "div2_b", M, 0, 0, 0, M, mb(11));
    t = ins(K_DIV, 12, 3, 4); t.dr = 1'b1;
    step(t, "div2_c", 0, M, 0, 0, M, mb(11));
    step(idle(), "div2_d", 0, 0, 0, 0, M, mb(12));
    t = idle(); t.dr = 1'b1;
    step(t, "div2_e", 0, 0, 0, 0, M, mb(12));
    step(t, "div_rdy_idle", 0, 0, 0, 0, 0, 32'h0);

    // x0 never pending
    step(ins(K_LD, 0, 1, 0),  "x0_ld",   0, 0, 0, 0, 0, 32'h0);
    step(ins(K_ALU, 1, 0, 0), "x0_use",  0, 0, 0, 0, 0, 32'h0);
    step(ins(K_MUL, 0, 3, 4), "x0_mul",  0, 0, 0, 0, 0, 32'h0);
    step(ins(K_ALU, 2, 0, 0), "x0_use2", 0, 0, 0, M, 0, 32'h0);
    step(idle(),              "x0_m1",   0, 0, 0, M, 0, 32'h0);
    step(idle(),              "x0_m2",   0, 0, M, M, 0, 32'h0);
    step(idle(),              "x0_m3",   0, 0, 0, 0, 0, 32'h0);

    // flush kills issue and suppresses stall, but not tracking
    t = ins(K_LD, 13, 1, 0); t.fl = 1'b1;
    step(t,                    "fl_ld",   0, 0, 0, 0, 0, 32'h0);
    step(ins(K_ALU, 14, 13, 1), "fl_use", 0, 0, 0, 0, 0, 32'h0);
    step(ins(K_LD, 15, 1, 0),  "fl_ld2",  0, 0, 0, 0, 0, 32'h0);
    t = ins(K_ALU, 16, 15, 1); t.fl = 1'b1;
    step(t,                    "fl_stall", 0, 0, 0, 0, 0, b(15));
    step(idle(),               "fl_idle",  0, 0, 0, 0, 0, 32'h0);

    // async reset mid-divide
    step(ins(K_DIV, 9, 1, 2),  "rst_div",  0, M, 0, 0, 0, 32'h0);
    step(ins(K_ALU, 10, 9, 3), "rst_wait", M, 0, 0, 0, M, mb(9));
    t = idle(); t.rst = 1'b0;
    step(t,                    "rst_mid",  0, 0, 0, 0, 0, 32'h0);
    step(ins(K_ALU, 10, 9, 3), "rst_rel",  0, 0, 0, 0, 0, 32'h0);
    step(idle(),               "rst_idle", 0, 0, 0, 0, 0, 32'h0);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Issue-side hazard tracker for the 5-stage core, sitting between decode and execute. It records in-flight destination registers of long-latency producers (loads, multiply, divide), stalls ID while a source operand cannot yet be forwarded, and generates the `mul_ready`/`div_start` handshakes consumed by the EX-stage forwarding mux. It covers the hazards that forwarding cannot resolve; forwarding covers the rest.

## Interface
- `MUL_LAT`, default 3: fixed multiplier latency in cycles from issue to result valid, legal range 1..15.
- `clk` in 1: core clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ID_valid` in 1: the ID instruction is valid and requests issue.
- `ID_rs1`, `ID_rs2` in 5 each: source register numbers.
- `ID_use_rs1`, `ID_use_rs2` in 1 each: the instruction reads that source.
- `ID_rd` in 5: destination register.
- `ID_regwrite` in 1: the instruction writes `ID_rd`.
- `ID_memread` in 1: the instruction is a load.
- `ID_is_mul`, `ID_is_div` in 1 each: M-extension class.
- `flush` in 1: kills the ID instruction this cycle. No issue and no state set.
- `div_ready` in 1: divider result valid this cycle, single-cycle pulse.
- `stall` out 1: hold IF/ID, inject a bubble into EX.
- `div_start` out 1: one-cycle pulse to the divider on div issue.
- `mul_ready` out 1: multiplier result valid this cycle (feeds forwarding).
- `div_busy`, `mul_busy` out 1 each: unit occupied.
- `pending` out 32: per-register not-yet-forwardable mask. Bit 0 is always 0.

## Operation
- Issue: `issue = ID_valid & !stall & !flush`.
- Long-latency write: `lw = issue & ID_regwrite & (ID_rd != 0) & (ID_memread | ID_is_mul | ID_is_div)`.
- Load: on a load issue, set `pending[ID_rd]` and capture `ld_rd`. Clear it on the next edge, because the load result is forwardable from MEM/WB after one bubble.
- Multiply: only one multiply is in flight at a time.
  - On issue: `mul_busy`←1, `mul_cnt`←`MUL_LAT-1`, capture `mul_rd`, set `pending[mul_rd]`.
  - Each cycle `mul_busy` is set and `mul_cnt != 0`: decrement.
  - `mul_ready = mul_busy & (mul_cnt == 0)`. On that edge, clear `mul_busy` and `pending[mul_rd]`.
- Divide: only one divide is in flight at a time.
  - On issue: `div_start`=1 for exactly that cycle, `div_busy`←1, capture `div_rd`, set `pending[div_rd]`.
  - `div_ready` while `div_busy`: clear `div_busy` and `pending[div_rd]`.
  - `div_ready` while not busy: ignore.
- `stall = ID_valid & !flush & (raw | waw | struct)`, where:
  - `raw = (ID_use_rs1 & hit(ID_rs1)) | (ID_use_rs2 & hit(ID_rs2))`.
  - `hit(r) = pending[r] & !(r == mul_rd & mul_ready) & !(r == div_rd & div_ready & div_busy)`. Completion this cycle is bypassed through forwarding, so it causes no stall.
  - `waw = ID_regwrite & (ID_rd != 0) & hit(ID_rd)`.
  - `struct = (ID_is_mul & mul_busy & !mul_ready) | (ID_is_div & div_busy & !(div_ready))`.
- Same-cycle set and clear of the same register bit: set wins, because a new issue overrides a completion.
- Register x0 is never marked pending and never causes a stall.

## Timing
- `stall` is combinational from ID inputs and registered state. There is no cycle of latency.
- Load followed by a dependent instruction: exactly 1 stall cycle.
- Multiply followed by a dependent instruction issued next: stall for `MUL_LAT-1` cycles, then issue in the `mul_ready` cycle.
- `div_start` is asserted in the cycle `issue` occurs. The earliest legal `div_ready` is the following cycle.
- Reset, applied asynchronously at any time including mid-divide:
  - `pending`=0, `mul_busy`=0, `div_busy`=0, `mul_cnt`=0.
  - `div_start`=0, `mul_ready`=0, `stall`=0 (when inputs are idle).
  - The divider is reset by the same `rst_n`.
- `flush` does not affect in-flight mul/div/load tracking.

## Configuration
- `RV32M_EN` defined: multiply/divide tracking as above.
- `RV32M_EN` undefined:
  - `ID_is_mul`/`ID_is_div` are ignored.
  - `mul_busy`, `div_busy`, `mul_ready`, `div_start` are tied to 0.
  - Only loads set `pending`.
  - The `mul_*`/`div_*` registers are not instantiated.

## Test plan
- Load x5, then `add x6,x5,x1` next cycle -> `stall`=1 for one cycle, `pending[5]`=1 then 0, add issues on the 2nd cycle.
- `MUL_LAT`=3: `mul x7` then dependent `sub x8,x7,x2` -> `stall` high 2 cycles, `mul_ready`=1 in the issue cycle of `sub`, `pending[7]` cleared.
- `div x9` (`div_start` pulse), dependent `or` waits. Drive `div_ready` after 10 cycles -> `stall` drops the same cycle, `div_busy`→0.
- Second div while busy -> structural stall until `div_ready`. Issue in that cycle gives a new `div_start`, and `pending[new rd]` stays 1.
- Load to x0, and mul to x0 with consumer of x0 -> no stall, `pending`=0.
- Assert `rst_n`=0 mid-divide with `pending[9]`=1 -> all outputs 0 immediately. After release, dependent x9 instruction issues without stall.
